// File: rtl/point_link_rx_fifo_pkg.sv
// Shared definitions for the point-link receive FIFO: link_i bit positions,
// valid-bit locator, FIFO occupancy states and a clog2 helper.
package point_link_pkg;

   // Bit positions inside the 2-bit link_i status word
   localparam int LINK_STALL = 0;
   localparam int LINK_OVF   = 1;

   // Occupancy view of the FIFO, decoded from the entry count
   typedef enum logic [1:0] {
      ST_EMPTY  = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_FULL   = 2'd2
   } fifo_state_t;

   // The valid flag sits just above the payload on link_o
   function automatic int VALID_BIT(input int data_w);
      return data_w;
   endfunction

   // Ceiling log2, minimum result 1 so address buses never collapse to zero width
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      if (r < 1) r = 1;
      return r;
   endfunction

endpackage

// File: rtl/point_link_rx_fifo_if.sv
// Bundle of link-side and core-side signals of the point-link receive FIFO.
// Optional statistics signals exist only when POINT_LINK_RX_STATS_EN is defined.
interface point_link_rx_fifo_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W:0]   link_o;     // {valid, payload} from the remote master
   logic [1:0]        link_i;     // {overflow, stall} back to the remote master
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_ready;
   logic              ovf_clear;
`ifdef POINT_LINK_RX_STATS_EN
   logic [31:0]       rx_count;
   logic [15:0]       drop_count;
`endif

   // The receive FIFO itself
   modport slave (
      input  link_o, out_ready, ovf_clear,
      output link_i, out_valid, out_data
`ifdef POINT_LINK_RX_STATS_EN
      , output rx_count, drop_count
`endif
   );

   // Whoever feeds the link and consumes the buffered words
   modport master (
      output link_o, out_ready, ovf_clear,
      input  link_i, out_valid, out_data
`ifdef POINT_LINK_RX_STATS_EN
      , input rx_count, input drop_count
`endif
   );
endinterface

// File: rtl/point_link_rx_fifo_mem.sv
// DEPTH x DATA_W storage for the receive FIFO: one synchronous write port and
// an asynchronous read port so the head entry is visible without a read cycle.
// The array carries no reset; validity is tracked by the owner's count.
module point_fifo_mem
   import point_link_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 8,
   parameter int AW     = clog2(DEPTH)
) (
   input  logic              clock,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [AW-1:0]     rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] r_mem [DEPTH];

   // Write the incoming word into its slot
   always_ff @(posedge clock) begin
      if (wr_en) r_mem[wr_addr] <= wr_data;
   end

   assign rd_data = r_mem[rd_addr];

endmodule

// File: rtl/point_link_rx_fifo.sv
// Receive stage behind the point-link slave interface. Buffers the framed word
// stream in a FIFO, hands it to the core with valid/ready, and reports stall
// and sticky overflow back to the remote master over link_i.
// Optional feature macro: POINT_LINK_RX_STATS_EN (rx_count / drop_count).
module point_link_rx_fifo
   import point_link_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 8,
   parameter int SKID   = 2
) (
   input  logic                   clock,
   input  logic                   reset_n,
   point_link_rx_fifo_if.slave    bus
);

   localparam int AW = clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int VB = VALID_BIT(DATA_W);
   localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
   localparam logic [CW-1:0] C_SKID  = CW'(SKID);

   logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
   logic [CW-1:0]     r_count;
   logic              r_valid, r_stall, r_ovf;

   logic [AW-1:0]     w_wr_ptr_next, w_rd_ptr_next;
   logic [CW-1:0]     w_count_next, w_free;
   logic              w_push, w_pop, w_push_acc, w_drop;
   logic              w_stall_next, w_ovf_next;
   fifo_state_t       w_state;
   logic [DATA_W-1:0] w_rd_data;
   logic [1:0]        w_link_i;

   // Only a clean 1 counts as valid; X/Z from an unsettled remote is ignored
   assign w_push = (bus.link_o[VB] === 1'b1);

   // Occupancy state decoded straight from the count register
   always_comb begin
      w_state = ST_ACTIVE;
      if (r_count == '0)          w_state = ST_EMPTY;
      else if (r_count == C_DEPTH) w_state = ST_FULL;
   end

   // Next pointers, count, stall and overflow from this cycle's push/pop
   always_comb begin
      w_pop         = r_valid && bus.out_ready && (w_state != ST_EMPTY);
      // A full FIFO still accepts when the head leaves in the same cycle
      w_push_acc    = w_push && ((w_state != ST_FULL) || w_pop);
      w_drop        = w_push && !w_push_acc;
      w_wr_ptr_next = w_push_acc ? r_wr_ptr + AW'(1) : r_wr_ptr;
      w_rd_ptr_next = w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;
      w_count_next  = r_count;
      if (w_push_acc && !w_pop)      w_count_next = r_count + CW'(1);
      else if (!w_push_acc && w_pop) w_count_next = r_count - CW'(1);
      w_free        = C_DEPTH - w_count_next;
      w_stall_next  = (w_free <= C_SKID);
      // A fresh drop beats a simultaneous clear
      w_ovf_next    = w_drop ? 1'b1 : (bus.ovf_clear ? 1'b0 : r_ovf);
   end

   // FIFO control registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_valid  <= 1'b0;
         r_stall  <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         r_wr_ptr <= w_wr_ptr_next;
         r_rd_ptr <= w_rd_ptr_next;
         r_count  <= w_count_next;
         r_valid  <= (w_count_next != '0);
         r_stall  <= w_stall_next;
         r_ovf    <= w_ovf_next;
      end
   end

   point_fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_mem (
      .clock   (clock),
      .wr_en   (w_push_acc),
      .wr_addr (r_wr_ptr),
      .wr_data (bus.link_o[DATA_W-1:0]),
      .rd_addr (r_rd_ptr),
      .rd_data (w_rd_data)
   );

   // Output drive: head payload masked to zero while empty, status packed into link_i
   always_comb begin
      w_link_i             = '0;
      w_link_i[LINK_STALL] = r_stall;
      w_link_i[LINK_OVF]   = r_ovf;
   end

   assign bus.link_i    = w_link_i;
   assign bus.out_valid = r_valid;
   assign bus.out_data  = r_valid ? w_rd_data : '0;

`ifdef POINT_LINK_RX_STATS_EN
   logic [31:0] r_rx_count;
   logic [15:0] r_drop_count;

   // Traffic statistics; unaffected by ovf_clear
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_rx_count   <= '0;
         r_drop_count <= '0;
      end else begin
         if (w_push_acc) r_rx_count <= r_rx_count + 32'd1;
         if (w_drop && (r_drop_count != 16'hFFFF)) r_drop_count <= r_drop_count + 16'd1;
      end
   end

   assign bus.rx_count   = r_rx_count;
   assign bus.drop_count = r_drop_count;
`endif

endmodule
